mem_access_ctrl: RTL

Initiator-side memory access controller for the 16-bit MCU datapath. It accepts one load or store request at a time from the control FSM, registers the address into MAR and the data into MDR, and drives the memory enable/write strobes. It waits for the memory ready handshake, captures read data into MDR and returns a single-cycle response. It is the master end of the MAR/MDR memory interface and is the only block that drives memory strobes.

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/mem_timeout_ctr.sv | 37 +++
 rtl/mem_access_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the MAR/MDR memory interface.
// Other datapath blocks import the width constants from here as well.
package mem_ctrl_pkg;

  localparam int unsigned MemAddrW = 16;
  localparam int unsigned MemDataW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } mem_state_e;

  typedef enum logic {
    OpLoad,
    OpStore
  } mem_op_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating wait-cycle counter for the memory access controller.
// The hit output is high once the count has reached TIMEOUT.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == CntMax);

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side memory access controller: one load/store at a time through MAR/MDR,
// waits for mem_rdy with a timeout, and returns a one-cycle response.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = MemAddrW,
  parameter int unsigned DATA_W  = MemDataW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mar,
  output logic [DATA_W-1:0] mdr,
  output logic              mem_en,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy
);

  mem_state_e        state_q, state_d;
  mem_op_e           op_q, op_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              err_q, err_d;
  logic              ctr_clr, ctr_en, ctr_hit;

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (ctr_clr),
    .en_i  (ctr_en),
    .hit_o (ctr_hit)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    err_d   = err_q;
    ctr_clr = 1'b0;
    ctr_en  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          mar_d   = req_addr;
          op_d    = req_we ? OpStore : OpLoad;
          ctr_clr = 1'b1;
          state_d = StAccess;
          if (req_we) begin
            mdr_d = req_wdata;
          end
        end
      end
      StAccess: begin
        // mem_rdy wins over a simultaneous timeout hit.
        if (mem_rdy) begin
          if (op_q == OpLoad) begin
            mdr_d = mem_rdata;
          end
          err_d   = 1'b0;
          state_d = StDone;
        end else if (ctr_hit) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          ctr_en = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpLoad;
      mar_q   <= '0;
      mdr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
    end
  end

  // Strobes and handshakes decode from registered state only.
  assign req_ready  = (state_q == StIdle);
  assign mem_en     = (state_q == StAccess);
  assign mem_we     = (state_q == StAccess) && (op_q == OpStore);
  assign resp_valid = (state_q == StDone);
  assign resp_err   = (state_q == StDone) && err_q;
  assign mar        = mar_q;
  assign mdr        = mdr_q;

endmodule
